// File: rtl/beat_seq_pkg.sv
// rtl/beat_seq_pkg.sv - shared state encoding, beat constants and defaults for beat_sequencer
package beat_seq_pkg;

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    B1    = 3'd1,
    B2    = 3'd2,
    B3    = 3'd3,
    PAUSE = 3'd4
  } beat_state_t;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_1    = 3'b001;
  localparam logic [2:0] W_2    = 3'b010;
  localparam logic [2:0] W_3    = 3'b100;

  localparam int CNT_W_DEFAULT = 8;

  function automatic logic [2:0] w_of(beat_state_t s);
    case (s)
      B1:      return W_1;
      B2:      return W_2;
      B3:      return W_3;
      default: return W_NONE;
    endcase
  endfunction

endpackage

// File: rtl/qd_sync_edge.sv
// rtl/qd_sync_edge.sv - two-flop QD synchronizer with rising-edge detect on the T3 falling edge
module qd_sync_edge (
  input  logic T3,
  input  logic CLR,
  input  logic QD,
  output logic start
);

  logic qd_s1;
  logic qd_s2;

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      qd_s1 <= 1'b0;
      qd_s2 <= 1'b0;
    end else begin
      qd_s1 <= QD;
      qd_s2 <= qd_s1;
    end
  end

  assign start = qd_s1 & ~qd_s2;

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - W[3:1] beat generator with SHORT/LONG/STOP control; BEAT_SEQ_STEP_EN adds single-step PAUSE
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
`ifdef BEAT_SEQ_STEP_EN
  input  logic             STEP,
`endif
  output logic [2:0]       W,
  output logic             RUN,
  output logic [CNT_W-1:0] CYC_CNT
);

  beat_state_t state;
  beat_state_t nxt;
  logic        start;
  logic        cyc_end;
  logic        in_beat;

  qd_sync_edge u_qd_sync_edge (
    .T3    (T3),
    .CLR   (CLR),
    .QD    (QD),
    .start (start)
  );

  assign in_beat = (state == B1) || (state == B2) || (state == B3);

`ifdef BEAT_SEQ_STEP_EN
  logic [1:0] resume;
  logic       go_pause;

  // STOP outranks STEP, so only non-stop beat transitions are parked
  assign go_pause = STEP && !STOP && in_beat;
`endif

  always_comb begin
    nxt     = state;
    cyc_end = 1'b0;
    case (state)
      HALT: if (start) nxt = B1;
      B1: begin
        if (STOP) begin
          nxt     = HALT;
          cyc_end = 1'b1;
        end else if (SHORT) begin
          nxt     = B1;
          cyc_end = 1'b1;
        end else begin
          nxt = B2;
        end
      end
      B2: begin
        if (STOP) begin
          nxt     = HALT;
          cyc_end = 1'b1;
        end else if (LONG) begin
          nxt = B3;
        end else begin
          nxt     = B1;
          cyc_end = 1'b1;
        end
      end
      B3: begin
        nxt     = STOP ? HALT : B1;
        cyc_end = 1'b1;
      end
`ifdef BEAT_SEQ_STEP_EN
      PAUSE: if (start) nxt = beat_state_t'({1'b0, resume});
`endif
      default: nxt = HALT;
    endcase
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state   <= HALT;
      W       <= W_NONE;
      RUN     <= 1'b0;
      CYC_CNT <= '0;
`ifdef BEAT_SEQ_STEP_EN
      resume  <= 2'd1;
`endif
    end else begin
      if (cyc_end) CYC_CNT <= CYC_CNT + 1'b1;
`ifdef BEAT_SEQ_STEP_EN
      if (go_pause) begin
        state  <= PAUSE;
        W      <= W_NONE;
        RUN    <= 1'b0;
        resume <= 2'(nxt);
      end else begin
        state <= nxt;
        W     <= w_of(nxt);
        RUN   <= (w_of(nxt) != W_NONE);
        if (STOP && in_beat) resume <= 2'd1;
      end
`else
      state <= nxt;
      W     <= w_of(nxt);
      RUN   <= (w_of(nxt) != W_NONE);
`endif
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - self-checking bench for beat_sequencer with a beat-level reference model
module tb_beat_sequencer;

  localparam int CNT_W = 8;

  logic T3 = 1'b1;
  logic CLR = 1'b0;
  logic QD = 1'b0;
  logic SHORT = 1'b0;
  logic LONG = 1'b0;
  logic STOP = 1'b0;
`ifdef BEAT_SEQ_STEP_EN
  logic STEP = 1'b0;
`endif
  logic [2:0]       W;
  logic             RUN;
  logic [CNT_W-1:0] CYC_CNT;

  int errors = 0;
  int checks = 0;

  // model: beat number 0 = halted, 1..3 = W1..W3, 4 = paused
  int m_beat = 0;
  int m_resume = 1;
  int m_cnt = 0;
  bit m_q1 = 0;
  bit m_q2 = 0;

  beat_sequencer #(.CNT_W(CNT_W)) dut (
    .T3      (T3),
    .CLR     (CLR),
    .QD      (QD),
    .SHORT   (SHORT),
    .LONG    (LONG),
    .STOP    (STOP),
`ifdef BEAT_SEQ_STEP_EN
    .STEP    (STEP),
`endif
    .W       (W),
    .RUN     (RUN),
    .CYC_CNT (CYC_CNT)
  );

  initial forever #5 T3 = ~T3;

  function automatic logic [2:0] beat_to_w(int b);
    case (b)
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_edge();
    bit start;
    bit ended;
    bit step_on;
    int tgt;
    start = m_q1 && !m_q2;
    m_q2 = m_q1;
    m_q1 = QD;
    ended = 0;
    tgt = m_beat;
    step_on = 0;
`ifdef BEAT_SEQ_STEP_EN
    step_on = STEP;
`endif
    if (m_beat == 0 || m_beat == 4) begin
      if (start) tgt = (m_beat == 0) ? 1 : m_resume;
    end else if (STOP) begin
      tgt = 0;
      ended = 1;
      m_resume = 1;
    end else begin
      if (m_beat == 1) begin
        tgt = SHORT ? 1 : 2;
        ended = SHORT;
      end else if (m_beat == 2 && LONG) begin
        tgt = 3;
      end else begin
        tgt = 1;
        ended = 1;
      end
      if (step_on) begin
        m_resume = tgt;
        tgt = 4;
      end
    end
    m_beat = tgt;
    if (ended) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic tick();
    @(negedge T3);
    model_edge();
    #1;
  endtask

  task automatic hard_reset();
    CLR = 1'b0;
    m_beat = 0;
    m_cnt = 0;
    m_q1 = 0;
    m_q2 = 0;
    m_resume = 1;
    #1;
  endtask

  task automatic press();
    QD = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    hard_reset();
    checks++;
    if (W !== 3'b000 || RUN !== 1'b0 || CYC_CNT !== '0) begin
      errors++;
      $display("FAIL reset: W=%b RUN=%b CYC_CNT=%0d, want W=000 RUN=0 CYC_CNT=0", W, RUN, CYC_CNT);
    end
    CLR = 1'b1;
    tick();
    checks++;
    if (W !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: W=%b, want 000", W);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_w;
    press();
    checks++;
    if (W !== 3'b001 || RUN !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: W=%b RUN=%b, want 001 1", W, RUN);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_w = (i % 2 == 0) ? 3'b010 : 3'b001;
      checks++;
      if (W !== exp_w || W !== beat_to_w(m_beat)) begin
        errors++;
        $display("FAIL basic_w[%0d]: W=%b, want %b", i, W, exp_w);
      end
      checks++;
      if (CYC_CNT !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL basic_cnt[%0d]: CYC_CNT=%0d, want %0d", i, CYC_CNT, m_cnt);
      end
    end
    checks++;
    if (CYC_CNT !== 8'd3) begin
      errors++;
      $display("FAIL basic_cnt_after6: CYC_CNT=%0d, want 3", CYC_CNT);
    end
    QD = 1'b0;
  endtask

  task automatic test_short_wrap();
    hard_reset();
    CLR = 1'b1;
    press();
    QD = 1'b0;
    SHORT = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (W !== 3'b001 || CYC_CNT !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL short[%0d]: W=%b CYC_CNT=%0d, want 001 %0d", i, W, CYC_CNT, m_cnt);
      end
    end
    checks++;
    if (CYC_CNT !== 8'd0) begin
      errors++;
      $display("FAIL short_wrap: CYC_CNT=%0d, want 0", CYC_CNT);
    end
    SHORT = 1'b0;
  endtask

  task automatic test_long();
    logic [2:0] exp_w [3];
    int exp_c [3];
    exp_w = '{3'b010, 3'b100, 3'b001};
    exp_c = '{0, 0, 1};
    hard_reset();
    CLR = 1'b1;
    press();
    QD = 1'b0;
    LONG = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (W !== exp_w[i] || CYC_CNT !== CNT_W'(exp_c[i])) begin
        errors++;
        $display("FAIL long[%0d]: W=%b CYC_CNT=%0d, want %b %0d", i, W, CYC_CNT, exp_w[i], exp_c[i]);
      end
    end
    LONG = 1'b0;
  endtask

  task automatic test_stop();
    hard_reset();
    CLR = 1'b1;
    press();
    tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    checks++;
    if (W !== 3'b000 || RUN !== 1'b0 || CYC_CNT !== 8'd1) begin
      errors++;
      $display("FAIL stop: W=%b RUN=%b CYC_CNT=%0d, want 000 0 1", W, RUN, CYC_CNT);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (W !== 3'b000) begin
        errors++;
        $display("FAIL stop_qd_held[%0d]: W=%b, want 000", i, W);
      end
    end
    QD = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    checks++;
    if (W !== 3'b000) begin
      errors++;
      $display("FAIL restart_early: W=%b, want 000", W);
    end
    tick();
    checks++;
    if (W !== 3'b001) begin
      errors++;
      $display("FAIL restart: W=%b, want 001", W);
    end
    QD = 1'b0;
  endtask

  task automatic test_clr_mid();
    hard_reset();
    CLR = 1'b1;
    press();
    QD = 1'b0;
    SHORT = 1'b1;
    repeat (5) tick();
    SHORT = 1'b0;
    tick();
    LONG = 1'b1;
    tick();
    LONG = 1'b0;
    checks++;
    if (W !== 3'b100 || CYC_CNT !== 8'd5) begin
      errors++;
      $display("FAIL pre_clr: W=%b CYC_CNT=%0d, want 100 5", W, CYC_CNT);
    end
    #2;
    hard_reset();
    checks++;
    if (W !== 3'b000 || RUN !== 1'b0 || CYC_CNT !== 8'd0) begin
      errors++;
      $display("FAIL clr_async: W=%b RUN=%b CYC_CNT=%0d, want 000 0 0", W, RUN, CYC_CNT);
    end
    #1;
    CLR = 1'b1;
  endtask

`ifdef BEAT_SEQ_STEP_EN
  task automatic test_step();
    logic [2:0] exp_w [5];
    exp_w = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
    hard_reset();
    CLR = 1'b1;
    STEP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) press(); else tick();
      checks++;
      if (W !== exp_w[i] || W !== beat_to_w(m_beat)) begin
        errors++;
        $display("FAIL step[%0d]: W=%b, want %b", i, W, exp_w[i]);
      end
    end
    QD = 1'b0;
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    checks++;
    if (W !== 3'b000 || CYC_CNT !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL step_stop: W=%b CYC_CNT=%0d, want 000 %0d", W, CYC_CNT, m_cnt);
    end
    press();
    checks++;
    if (W !== 3'b001) begin
      errors++;
      $display("FAIL step_resume_cleared: W=%b, want 001", W);
    end
    STEP = 1'b0;
    QD = 1'b0;
  endtask
`endif

  task automatic test_random();
    hard_reset();
    CLR = 1'b1;
    for (int i = 0; i < 800; i++) begin
      QD    = ($urandom_range(0, 3) == 0) ? ~QD : QD;
      SHORT = 1'($urandom_range(0, 1));
      LONG  = 1'($urandom_range(0, 1));
      STOP  = ($urandom_range(0, 15) == 0);
`ifdef BEAT_SEQ_STEP_EN
      STEP  = ($urandom_range(0, 3) == 0);
`endif
      tick();
      checks++;
      if (W !== beat_to_w(m_beat) || RUN !== (m_beat >= 1 && m_beat <= 3) || CYC_CNT !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: W=%b RUN=%b CYC_CNT=%0d, want %b %0d %0d",
                 i, W, RUN, CYC_CNT, beat_to_w(m_beat), (m_beat >= 1 && m_beat <= 3), m_cnt);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2;
        hard_reset();
        checks++;
        if (W !== 3'b000 || CYC_CNT !== '0) begin
          errors++;
          $display("FAIL random_clr[%0d]: W=%b CYC_CNT=%0d, want 000 0", i, W, CYC_CNT);
        end
        CLR = 1'b1;
      end
    end
    SHORT = 1'b0;
    LONG = 1'b0;
    STOP = 1'b0;
    QD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_wrap();
    test_long();
    test_stop();
    test_clr_mid();
`ifdef BEAT_SEQ_STEP_EN
    test_step();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
